fifo1c_gen: RTL and testbench
=============================

# fifo1c_gen

Parametrised single-clock FIFO, the general successor to the fixed 16x64 link-engine FIFO. It adds configurable width, depth and thresholds, a selectable first-word-fall-through (show-ahead) read mode, sticky error flags with a clear, and a peak-occupancy watermark. It sits between link-engine producers and consumers in one clock domain, with inference-friendly dual-port RAM underneath.

## Interface
- DATA_WIDTH, 64, word width in bits
- ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH, minimum 2
- AFUL_THRES, DEPTH-1, almost_full asserted when usedw >= AFUL_THRES
- AEMP_THRES, 1, almost_empty asserted when usedw <= AEMP_THRES
- SHOWAHEAD, 0, 0 = normal read (rdreq requests data); 1 = FWFT (q shows head, rdreq acknowledges)
- PIPE, 1, 1 = extra output register on q in normal mode; ignored when SHOWAHEAD=1
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- data  in  DATA_WIDTH  write data
- wrreq  in  1  write request
- rdreq  in  1  read request / acknowledge
- highest_clr  in  1  reload watermark with current usedw
- err_clr  in  1  clear sticky error flags
- q  out  DATA_WIDTH  read data
- empty, full  out  1  status
- almost_empty, almost_full  out  1  threshold status
- usedw  out  ADDR_WIDTH+1  occupancy, 0..DEPTH
- highest_dw  out  ADDR_WIDTH+1  peak usedw since reset/clear
- overflow, underflow  out  1  one-cycle pulse on rejected write/read
- ovf_sticky, udf_sticky  out  1  latched error flags

## Operation
- Pointers wa, ra are ADDR_WIDTH bits and wrap modulo DEPTH; occupancy held in a separate (ADDR_WIDTH+1)-bit counter, not derived from pointers.
- Write accepted iff wrreq && !full, or wrreq && full && accepted read in the same cycle (normal mode only). Rejected write: no state change, overflow pulses.
- Read accepted iff rdreq && !empty. Rejected read: no state change, underflow pulses. Write into empty FIFO plus rdreq same cycle: write accepted, read rejected.
- Simultaneous accepted read and write: usedw unchanged; pointers both advance.
- FWFT mode: one-entry output stage prefetches from RAM; empty reflects output-stage valid; usedw counts RAM entries plus output stage; full at DEPTH total, so simultaneous read/write at full rejects the write.
- highest_dw: each cycle takes max(highest_dw, usedw_next); highest_clr loads usedw_next (clear wins).
- Sticky flags set on pulse, cleared by err_clr; set wins if both the same cycle.
- Reset: pointers, usedw, highest_dw, all error outputs 0; empty=1, almost_empty=1, full=0, almost_full=0 (AFUL_THRES>0); q=0. RAM contents not reset. Reset mid-operation discards all data.

## Timing
- All outputs registered; status and usedw update in cycle N+1 for a request in cycle N.
- Normal, PIPE=0: q valid cycle N+1 after accepted rdreq in cycle N; PIPE=1: cycle N+2. q holds between reads.
- FWFT: write into empty FIFO in cycle N gives empty=0 and valid q in cycle N+2; rdreq acknowledged in cycle N presents next word (or empty=1) in cycle N+1; back-to-back reads sustain one word per cycle.
- Throughput: one write and one read per cycle, no bubbles.

## Structure
- Package fifo1c_pkg: SHOWAHEAD mode constants and a usedw-width helper function (ADDR_WIDTH+1).
- Sub-module ram1r1w_gen (DATA_WIDTH, ADDR_WIDTH): simple dual-port RAM, registered read address, one-cycle read latency.
- Control, counters, watermark and FWFT prefetch stage in fifo1c_gen itself.

## Test plan
- DATA_WIDTH=64, ADDR_WIDTH=4, normal, PIPE=1: write 16 words 0..15 -> full=1 and usedw=16 at cycle after 16th write; 17th wrreq -> overflow pulse, ovf_sticky=1, data unchanged; read 16 -> q=0..15, each 2 cycles after rdreq.
- Empty FIFO, rdreq -> underflow pulse 1 cycle, udf_sticky=1; err_clr -> udf_sticky=0.
- Full FIFO, wrreq+rdreq same cycle (normal) -> both accepted, usedw stays 16; in SHOWAHEAD=1 -> overflow pulse, usedw 15.
- SHOWAHEAD=1, write 0xA5 at cycle N -> empty=0, q=0xA5 at N+2; continuous write/read of 100 words -> in-order, zero bubbles.
- Fill to 10, drain to 3, highest_clr -> highest_dw=10 then 3; AFUL_THRES=12/AEMP_THRES=2 thresholds toggle at usedw 12 and 2.
- Pointer wrap: 3 full fill/drain cycles with ADDR_WIDTH=2 -> data intact; assert rst_n low mid-burst -> all reset values next cycle.

Source files
------------

// File: rtl/fifo1c_pkg.sv
// fifo1c_pkg: shared constants for the fifo1c_gen FIFO.
//   SHOWAHEAD_NORMAL / SHOWAHEAD_FWFT : read-mode selectors for SHOWAHEAD
//   usedw_w()                         : occupancy width, one bit wider than
//                                       the address so DEPTH itself fits
package fifo1c_pkg;
  localparam int SHOWAHEAD_NORMAL = 0;
  localparam int SHOWAHEAD_FWFT   = 1;

  function automatic int usedw_w(input int aw);
    return aw + 1;
  endfunction
endpackage

// File: rtl/ram1r1w_gen.sv
// ram1r1w_gen: simple dual-port RAM, one write port, one read port.
//   clk, rst_n      : clock, synchronous active-low reset (read register only)
//   we/waddr/wdata  : write port
//   re/raddr        : read enable and address, sampled at the clock edge
//   rdata           : read data, one cycle after re; holds while re is low
// A read and a write to the same address in one cycle returns the old word,
// which the FIFO relies on when reading and writing a full buffer.
module ram1r1w_gen #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the output register is reset; array contents are not.
  always_ff @(posedge clk) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/fifo1c_gen.sv
// fifo1c_gen: parametrised single-clock FIFO.
//   clk, rst_n                 : clock, synchronous active-low reset
//   data, wrreq                : write data / request
//   rdreq                      : read request (normal) or acknowledge (FWFT)
//   highest_clr, err_clr       : reload watermark / clear sticky errors
//   q                          : read data
//   empty, full                : status
//   almost_empty, almost_full  : usedw <= AEMP_THRES / usedw >= AFUL_THRES
//   usedw, highest_dw          : occupancy and its peak since reset/clear
//   overflow, underflow        : one-cycle pulse on a rejected request
//   ovf_sticky, udf_sticky     : latched error flags
// In FWFT mode the RAM read register doubles as the one-entry output stage;
// empty is then the inverse of "output stage holds a word".
module fifo1c_gen import fifo1c_pkg::*; #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 4,
  parameter int AFUL_THRES = (1 << ADDR_WIDTH) - 1,
  parameter int AEMP_THRES = 1,
  parameter int SHOWAHEAD  = SHOWAHEAD_NORMAL,
  parameter int PIPE       = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [DATA_WIDTH-1:0]           data,
  input  logic                            wrreq,
  input  logic                            rdreq,
  input  logic                            highest_clr,
  input  logic                            err_clr,
  output logic [DATA_WIDTH-1:0]           q,
  output logic                            empty,
  output logic                            full,
  output logic                            almost_empty,
  output logic                            almost_full,
  output logic [usedw_w(ADDR_WIDTH)-1:0]  usedw,
  output logic [usedw_w(ADDR_WIDTH)-1:0]  highest_dw,
  output logic                            overflow,
  output logic                            underflow,
  output logic                            ovf_sticky,
  output logic                            udf_sticky
);
  localparam int            UW      = usedw_w(ADDR_WIDTH);
  localparam logic [UW-1:0] DEPTH_U = UW'(1 << ADDR_WIDTH);
  localparam logic [UW-1:0] AFUL_U  = UW'(AFUL_THRES);
  localparam logic [UW-1:0] AEMP_U  = UW'(AEMP_THRES);
  localparam bit            FWFT    = (SHOWAHEAD == SHOWAHEAD_FWFT);
  localparam bit            OREG    = !FWFT && (PIPE != 0);

  logic [ADDR_WIDTH-1:0] wa, ra;
  logic [DATA_WIDTH-1:0] rdata;
  logic [UW-1:0]         usedw_nxt;
  logic                  rd_acc, wr_acc, ram_re, prefetch, ovalid_nxt;

  always_comb begin
    rd_acc = rdreq && !empty;
    // In normal mode a read frees a slot in time for a same-cycle write;
    // in FWFT the output stage counts toward DEPTH, so full always rejects.
    if (FWFT) wr_acc = wrreq && !full;
    else      wr_acc = wrreq && (!full || rd_acc);
    // RAM holds usedw minus the word parked in the output stage (!empty).
    // Refill the stage whenever it is free or being acknowledged.
    prefetch   = FWFT && (usedw > UW'(!empty)) && (empty || rd_acc);
    ram_re     = FWFT ? prefetch : rd_acc;
    ovalid_nxt = prefetch || (!empty && !rd_acc);
    usedw_nxt  = usedw + UW'(wr_acc) - UW'(rd_acc);
  end

  ram1r1w_gen #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_acc),
    .waddr (wa),
    .wdata (data),
    .re    (ram_re),
    .raddr (ra),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wa           <= '0;
      ra           <= '0;
      usedw        <= '0;
      highest_dw   <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= (AFUL_U == '0);
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      ovf_sticky   <= 1'b0;
      udf_sticky   <= 1'b0;
    end else begin
      if (wr_acc) wa <= wa + 1'b1;
      if (ram_re) ra <= ra + 1'b1;
      usedw        <= usedw_nxt;
      empty        <= FWFT ? !ovalid_nxt : (usedw_nxt == '0);
      full         <= (usedw_nxt == DEPTH_U);
      almost_empty <= (usedw_nxt <= AEMP_U);
      almost_full  <= (usedw_nxt >= AFUL_U);
      highest_dw   <= (highest_clr || usedw_nxt > highest_dw) ? usedw_nxt : highest_dw;
      overflow     <= wrreq && !wr_acc;
      underflow    <= rdreq && !rd_acc;
      // Set takes priority over clear.
      ovf_sticky   <= (wrreq && !wr_acc) || (ovf_sticky && !err_clr);
      udf_sticky   <= (rdreq && !rd_acc) || (udf_sticky && !err_clr);
    end
  end

  generate
    if (OREG) begin : g_oreg
      logic                  rd_vld;
      logic [DATA_WIDTH-1:0] q_r;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rd_vld <= 1'b0;
          q_r    <= '0;
        end else begin
          rd_vld <= rd_acc;
          if (rd_vld) q_r <= rdata;
        end
      end
      assign q = q_r;
    end else begin : g_noreg
      assign q = rdata;
    end
  endgenerate
endmodule

// File: tb/tb_fifo1c_gen.sv
`timescale 1ns/1ps
module tb_fifo1c_gen;
  localparam int NK = 3;
  // k0: normal PIPE=1 depth 16; k1: FWFT depth 16; k2: normal PIPE=0 depth 4
  localparam int DEP [NK] = '{16, 16, 4};
  localparam bit FW  [NK] = '{1'b0, 1'b1, 1'b0};
  localparam int LAT [NK] = '{2, 0, 1};
  localparam int AFT [NK] = '{12, 12, 3};
  localparam int AET [NK] = '{2, 2, 1};

  logic        clk, rst_n, wrreq, rdreq, hclr, eclr;
  logic [63:0] data;
  logic [63:0] q_o [NK];
  logic        emp [NK], ful [NK], aemp [NK], aful [NK];
  logic        ovf [NK], udf [NK], ovs [NK], uds [NK];
  logic [4:0]  uw0, uw1, hw0, hw1;
  logic [2:0]  uw2, hw2;

  fifo1c_gen #(.DATA_WIDTH(64), .ADDR_WIDTH(4), .AFUL_THRES(12), .AEMP_THRES(2),
               .SHOWAHEAD(0), .PIPE(1)) u_n (
    .clk(clk), .rst_n(rst_n), .data(data), .wrreq(wrreq), .rdreq(rdreq),
    .highest_clr(hclr), .err_clr(eclr), .q(q_o[0]), .empty(emp[0]), .full(ful[0]),
    .almost_empty(aemp[0]), .almost_full(aful[0]), .usedw(uw0), .highest_dw(hw0),
    .overflow(ovf[0]), .underflow(udf[0]), .ovf_sticky(ovs[0]), .udf_sticky(uds[0]));

  fifo1c_gen #(.DATA_WIDTH(64), .ADDR_WIDTH(4), .AFUL_THRES(12), .AEMP_THRES(2),
               .SHOWAHEAD(1), .PIPE(1)) u_f (
    .clk(clk), .rst_n(rst_n), .data(data), .wrreq(wrreq), .rdreq(rdreq),
    .highest_clr(hclr), .err_clr(eclr), .q(q_o[1]), .empty(emp[1]), .full(ful[1]),
    .almost_empty(aemp[1]), .almost_full(aful[1]), .usedw(uw1), .highest_dw(hw1),
    .overflow(ovf[1]), .underflow(udf[1]), .ovf_sticky(ovs[1]), .udf_sticky(uds[1]));

  fifo1c_gen #(.DATA_WIDTH(64), .ADDR_WIDTH(2), .SHOWAHEAD(0), .PIPE(0)) u_s (
    .clk(clk), .rst_n(rst_n), .data(data), .wrreq(wrreq), .rdreq(rdreq),
    .highest_clr(hclr), .err_clr(eclr), .q(q_o[2]), .empty(emp[2]), .full(ful[2]),
    .almost_empty(aemp[2]), .almost_full(aful[2]), .usedw(uw2), .highest_dw(hw2),
    .overflow(ovf[2]), .underflow(udf[2]), .ovf_sticky(ovs[2]), .udf_sticky(uds[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each FIFO is a queue of (word, cycle written).
  typedef struct packed { logic [63:0] d; int wc; } ent_t;
  typedef struct packed { logic [63:0] d; int rdy; } pend_t;
  ent_t        mq  [NK][$];
  pend_t       pq  [NK][$];
  logic [63:0] mq_q [NK];
  int          mhw [NK];
  bit          movf [NK], mudf [NK], movs [NK], muds [NK], fq0 [NK];
  int          cyc, total, bad;

  // FWFT: the head word is visible two cycles after the cycle it was written.
  function automatic bit m_empty(input int k);
    if (FW[k]) return !(mq[k].size() > 0 && mq[k][0].wc <= cyc - 2);
    return mq[k].size() == 0;
  endfunction

  function automatic logic [63:0] uw_of(input int k);
    case (k)
      0:       return 64'(uw0);
      1:       return 64'(uw1);
      default: return 64'(uw2);
    endcase
  endfunction

  function automatic logic [63:0] hw_of(input int k);
    case (k)
      0:       return 64'(hw0);
      1:       return 64'(hw1);
      default: return 64'(hw2);
    endcase
  endfunction

  task automatic chkw(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s[%0d] got=%0h exp=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input int k, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s[%0d] got=%0b exp=%0b", tag, k, obs, exp);
    end
  endtask

  task automatic check_all();
    int u;
    bit me;
    for (int k = 0; k < NK; k++) begin
      u  = mq[k].size();
      me = m_empty(k);
      chkw("usedw",  k, uw_of(k), 64'(u));
      chk1("empty",  k, emp[k], me);
      chk1("full",   k, ful[k], u == DEP[k]);
      chk1("aempty", k, aemp[k], u <= AET[k]);
      chk1("afull",  k, aful[k], u >= AFT[k]);
      chkw("hdw",    k, hw_of(k), 64'(mhw[k]));
      chk1("ovf",    k, ovf[k], movf[k]);
      chk1("udf",    k, udf[k], mudf[k]);
      chk1("ovs",    k, ovs[k], movs[k]);
      chk1("uds",    k, uds[k], muds[k]);
      if (FW[k]) begin
        if (!me) begin
          chkw("q", k, q_o[k], mq[k][0].d);
          fq0[k] = 1'b0;
        end else if (fq0[k]) chkw("q", k, q_o[k], 64'd0);
      end else chkw("q", k, q_o[k], mq_q[k]);
    end
  endtask

  task automatic step();
    bit   rac [NK], wac [NK];
    ent_t e;
    pend_t p;
    for (int k = 0; k < NK; k++) begin
      rac[k] = rdreq && !m_empty(k);
      wac[k] = wrreq && (mq[k].size() < DEP[k] || (!FW[k] && rac[k]));
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NK; k++) begin
      if (!rst_n) begin
        mq[k].delete();
        pq[k].delete();
        mq_q[k] = '0; mhw[k] = 0; fq0[k] = 1'b1;
        movf[k] = 1'b0; mudf[k] = 1'b0; movs[k] = 1'b0; muds[k] = 1'b0;
      end else begin
        if (rac[k]) begin
          e = mq[k].pop_front();
          if (!FW[k]) begin
            p.d = e.d; p.rdy = cyc + LAT[k];
            pq[k].push_back(p);
          end
        end
        if (wac[k]) begin
          e.d = data; e.wc = cyc;
          mq[k].push_back(e);
        end
        movf[k] = wrreq && !wac[k];
        mudf[k] = rdreq && !rac[k];
        movs[k] = movf[k] || (movs[k] && !eclr);
        muds[k] = mudf[k] || (muds[k] && !eclr);
        if (hclr || mq[k].size() > mhw[k]) mhw[k] = mq[k].size();
      end
    end
    cyc++;
    for (int k = 0; k < NK; k++)
      while (pq[k].size() > 0 && pq[k][0].rdy <= cyc) begin
        p = pq[k].pop_front();
        mq_q[k] = p.d;
      end
    check_all();
  endtask

  task automatic cyc1(input bit w, input bit r, input logic [63:0] d);
    wrreq = w; rdreq = r; data = d;
    step();
  endtask

  initial begin
    int nb, pw;
    total = 0; bad = 0; cyc = 0;
    rst_n = 1'b0; wrreq = 1'b0; rdreq = 1'b0; hclr = 1'b0; eclr = 1'b0; data = '0;
    step(); step();
    chkw("rst_usedw", 0, uw_of(0), 64'd0);
    chk1("rst_empty", 0, emp[0], 1'b1);
    chk1("rst_aempty", 0, aemp[0], 1'b1);
    chk1("rst_afull", 0, aful[0], 1'b0);
    chkw("rst_q", 0, q_o[0], 64'd0);
    rst_n = 1'b1;

    // Fill 16, overflow, then full read+write in both modes.
    for (int i = 0; i < 16; i++) cyc1(1'b1, 1'b0, 64'(i));
    chk1("full16", 0, ful[0], 1'b1);
    chkw("usedw16", 0, uw_of(0), 64'd16);
    chk1("full16", 1, ful[1], 1'b1);
    cyc1(1'b1, 1'b0, 64'hDEAD);
    chk1("ovf17", 0, ovf[0], 1'b1);
    chk1("ovs17", 0, ovs[0], 1'b1);
    chkw("usedw17", 0, uw_of(0), 64'd16);
    cyc1(1'b1, 1'b1, 64'd100);
    chkw("rw_full_norm", 0, uw_of(0), 64'd16);
    chk1("rw_full_norm_ovf", 0, ovf[0], 1'b0);
    chkw("rw_full_fwft", 1, uw_of(1), 64'd15);
    chk1("rw_full_fwft_ovf", 1, ovf[1], 1'b1);
    for (int j = 0; j < 18; j++) begin
      cyc1(1'b0, 1'b1, '0);
      if (j < 16) chkw("rd_seq", 0, q_o[0], 64'(j));
    end
    cyc1(1'b0, 1'b0, '0);

    // Underflow pulse and sticky clear (set wins over clear).
    eclr = 1'b1; cyc1(1'b0, 1'b0, '0); eclr = 1'b0;
    chk1("uds_clr", 0, uds[0], 1'b0);
    cyc1(1'b0, 1'b1, '0);
    chk1("udf_pulse", 0, udf[0], 1'b1);
    chk1("uds_set", 0, uds[0], 1'b1);
    cyc1(1'b0, 1'b0, '0);
    chk1("udf_end", 0, udf[0], 1'b0);
    eclr = 1'b1; cyc1(1'b0, 1'b1, '0);
    chk1("uds_setwins", 0, uds[0], 1'b1);
    cyc1(1'b0, 1'b0, '0); eclr = 1'b0;
    chk1("uds_cleared", 0, uds[0], 1'b0);

    // FWFT first-word latency.
    cyc1(1'b1, 1'b0, 64'hA5);
    chk1("fwft_n1_empty", 1, emp[1], 1'b1);
    cyc1(1'b0, 1'b0, '0);
    chk1("fwft_n2_empty", 1, emp[1], 1'b0);
    chkw("fwft_n2_q", 1, q_o[1], 64'hA5);
    cyc1(1'b0, 1'b1, '0);
    repeat (3) cyc1(1'b0, 1'b0, '0);

    // Watermark and thresholds.
    hclr = 1'b1; cyc1(1'b0, 1'b0, '0); hclr = 1'b0;
    chkw("hdw_clr0", 0, hw_of(0), 64'd0);
    for (int i = 0; i < 10; i++) cyc1(1'b1, 1'b0, 64'(200 + i));
    chkw("hdw10", 0, hw_of(0), 64'd10);
    for (int i = 0; i < 7; i++) cyc1(1'b0, 1'b1, '0);
    chkw("usedw3", 0, uw_of(0), 64'd3);
    chkw("hdw_keep10", 0, hw_of(0), 64'd10);
    chk1("aempty_at3", 0, aemp[0], 1'b0);
    hclr = 1'b1; cyc1(1'b0, 1'b0, '0); hclr = 1'b0;
    chkw("hdw_reload3", 0, hw_of(0), 64'd3);
    cyc1(1'b0, 1'b1, '0);
    chk1("aempty_at2", 0, aemp[0], 1'b1);
    for (int i = 0; i < 9; i++) cyc1(1'b1, 1'b0, 64'(300 + i));
    chk1("afull_at11", 0, aful[0], 1'b0);
    cyc1(1'b1, 1'b0, 64'd399);
    chk1("afull_at12", 0, aful[0], 1'b1);
    for (int i = 0; i < 14; i++) cyc1(1'b0, 1'b1, '0);
    repeat (3) cyc1(1'b0, 1'b0, '0);

    // FWFT streaming: one word per cycle once primed.
    nb = 0;
    for (int i = 0; i < 100; i++) begin
      cyc1(1'b1, 1'b1, 64'(1000 + i));
      if (!emp[1]) nb++;
    end
    chkw("fwft_stream", 1, 64'(nb), 64'd99);
    for (int i = 0; i < 6; i++) cyc1(1'b0, 1'b1, '0);
    repeat (2) cyc1(1'b0, 1'b0, '0);

    // Pointer wrap on the depth-4 instance.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) cyc1(1'b1, 1'b0, 64'(5000 + r * 16 + i));
      chk1("wrap_full", 2, ful[2], 1'b1);
      for (int i = 0; i < 4; i++) cyc1(1'b0, 1'b1, '0);
    end
    for (int i = 0; i < 16; i++) cyc1(1'b0, 1'b1, '0);

    // Reset in the middle of a burst.
    for (int i = 0; i < 6; i++) cyc1(1'b1, (i > 2), 64'(7000 + i));
    rst_n = 1'b0; cyc1(1'b1, 1'b1, 64'd7777); rst_n = 1'b1;
    for (int k = 0; k < NK; k++) begin
      chkw("mrst_usedw", k, uw_of(k), 64'd0);
      chk1("mrst_empty", k, emp[k], 1'b1);
      chk1("mrst_ovs", k, ovs[k], 1'b0);
      chkw("mrst_hdw", k, hw_of(k), 64'd0);
      chkw("mrst_q", k, q_o[k], 64'd0);
    end
    cyc1(1'b0, 1'b0, '0);

    // Randomised traffic in fill/drain/balanced phases.
    for (int ph = 0; ph < 4; ph++) begin
      pw = (ph == 0) ? 80 : (ph == 1) ? 20 : (ph == 2) ? 50 : 65;
      for (int i = 0; i < 150; i++) begin
        wrreq = ($urandom_range(99) < 32'(pw));
        rdreq = ($urandom_range(99) < 32'(100 - pw));
        data  = {$urandom, $urandom};
        hclr  = ($urandom_range(31) == 0);
        eclr  = ($urandom_range(15) == 0);
        step();
      end
    end
    hclr = 1'b0; eclr = 1'b0;
    repeat (3) cyc1(1'b0, 1'b0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
